ofm_port_arbiter: RTL and testbench
===================================

# ofm_port_arbiter

Round-robin scheduler that shares the single read port of a byte-addressed filter/OFM memory between NREQ processing elements, forwards one write stream to the memory's independent write port, and sequences the memory's load, run and dump phases. It sits between the PE array and one memory instance. It issues the memory's load pulse at start, one read grant per cycle while running, and the single-cycle dump pulse once every PE has finished.

## Interface
- NREQ, 4: number of read requesters (2..8).
- AW, 10: byte read-address width; memory word index is addr[AW-1:2].
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins load/run from IDLE.
- req  in  NREQ  per-PE read request; held until granted.
- req_addr  in  NREQ*AW  packed byte addresses; PE i uses bits [i*AW +: AW].
- fin  in  NREQ  per-PE finished pulse or level; sticky-captured.
- wr_req  in  1  write request; always accepted.
- wr_addr  in  8  word write address.
- wr_data  in  32  write data.
- gnt  out  NREQ  one-hot grant pulse; PE may change req/addr the cycle after it sees gnt.
- rdata  out  8  read byte returned to the granted PE.
- rvalid  out  NREQ  one-hot; rdata is valid for PE i when rvalid[i]=1.
- busy  out  1  high in LOAD, RUN and FLUSH.
- mem_rst  out  1  memory load strobe.
- mem_read  out  1  memory read enable.
- mem_addr  out  AW  memory byte address.
- mem_rdata  in  8  combinational memory read byte.
- mem_we  out  1  memory write enable.
- mem_write_addr  out  8  memory write word address.
- mem_datai  out  32  memory write data.
- mem_done  out  1  memory dump strobe.

## Operation
- States are IDLE, LOAD, RUN, FLUSH and DONE. Reset enters IDLE.
- IDLE: when start=1, go to LOAD. All other inputs are ignored.
- LOAD: lasts exactly 1 cycle. mem_rst=1, then go to RUN.
- RUN arbitration:
  - Each cycle with any req bit set, pick winner w by round-robin.
  - Search starts at last_w+1 and wraps modulo NREQ. last_w resets to NREQ-1, so PE0 has first priority.
  - Register gnt=onehot(w), mem_read=1, mem_addr=req_addr[w], tag=w, and update last_w=w.
- Read return: the cycle after a grant, capture rdata=mem_rdata and set rvalid=onehot(tag).
- Requester hold rule: a PE whose gnt is high must drop or change req this cycle. If it keeps req asserted, that is a new request and is arbitrated again.
- Writes: in RUN and FLUSH, wr_req registers mem_we=1, mem_write_addr=wr_addr and mem_datai=wr_data, with 1-cycle latency. Writes are never blocked. In IDLE, LOAD and DONE, wr_req is dropped.
- Finish tracking: fin_seen |= fin in RUN. When fin_seen is all-ones, go to FLUSH. No grant is issued in the cycle the transition is taken.
- FLUSH: no grants. Wait until no read return and no write is in flight, then pulse mem_done for 1 cycle and go to DONE.
- DONE: all outputs idle; stays in DONE until rst.

## Timing
- Reset values: every output is 0, mem_addr=0, rdata=0, fin_seen=0, tag=0, last_w=NREQ-1.
- Read latency: req sampled at edge t gives gnt/mem_read high after t. rdata/rvalid are high after t+1.
- Throughput is one read per cycle; back-to-back grants to different PEs are allowed.
- Read/write hazard: same-word read and write in one cycle returns the pre-write data. A write at edge t is visible to reads granted at t+1 or later.
- Reset mid-operation: rst in any state clears in-flight grants and returns to IDLE. No mem_done is issued.
- A start pulse outside IDLE is ignored.
- fin with req pending: pending reqs remaining at the transition to FLUSH are never granted.
- mem_done is exactly one cycle, at least 2 cycles after the last grant.

## Test plan
- Reset, then start: mem_rst high for 1 cycle, busy=1 from the LOAD cycle onward, all other outputs 0.
- Set req=4'b1111 held continuously: grants go PE0, PE1, PE2, PE3, PE0, one per cycle. Each rvalid follows its gnt by 1 cycle with the byte at that PE's addr. Preload word 5=0xAABBCCDD with req_addr=22; rdata must be 0xBB.
- PE2 alone requests addr 0: gnt[2] after 1 edge, rvalid[2] and rdata=0xDD-style byte after 2 edges. The next grant to PE2 still follows round-robin from last_w=2.
- wr_req at word 3 with 0x11223344 in the same cycle as a read of byte 12 granted there: rdata is the old value. A read one cycle later returns 0x11.
- Assert fin for all PEs while req=4'b0011: no further gnt, exactly one mem_done pulse after in-flight returns, then DONE with busy=0 until rst.
- Assert rst during RUN with a grant in flight: next cycle every output is 0, state is IDLE, and no rvalid appears.

Source files
------------

// File: rtl/ofm_port_arbiter.sv
// Round-robin read-port scheduler and phase sequencer for one filter/OFM memory.
// Shares the read port among NREQ PEs, forwards writes, and drives load/dump strobes.
module ofm_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]   fin,
    input  logic              wr_req,
    input  logic [7:0]        wr_addr,
    input  logic [31:0]       wr_data,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        rdata,
    output logic [NREQ-1:0]   rvalid,
    output logic              busy,
    output logic              mem_rst,
    output logic              mem_read,
    output logic [AW-1:0]     mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_write_addr,
    output logic [31:0]       mem_datai,
    output logic              mem_done
);

    localparam int LW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state;
    logic [NREQ-1:0]   fin_seen;
    logic [LW-1:0]     last_w;
    logic [LW-1:0]     tag;

    logic [LW-1:0]     win;
    logic [NREQ-1:0]   win_oh;
    logic [AW-1:0]     win_addr;
    logic [NREQ-1:0]   tag_oh;
    logic              fin_all;
    logic              grant;
    logic              wr_ok;

    // Scan from last_w+1 upward; iterating in reverse lets the nearest requester win.
    function automatic logic [LW-1:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [LW-1:0]   last
    );
        logic [LW-1:0] p;
        int            idx;
        p = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (r[idx]) p = idx[LW-1:0];
        end
        return p;
    endfunction

    always_comb begin
        win      = rr_pick(req, last_w);
        win_oh   = '0;
        win_oh[win] = 1'b1;
        win_addr = req_addr[int'(win)*AW +: AW];
        tag_oh   = '0;
        tag_oh[tag] = 1'b1;
    end

    // A fin arriving this cycle already blocks the grant on the transition edge.
    assign fin_all = &(fin_seen | fin);
    assign grant   = (state == S_RUN) && !fin_all && (|req);
    assign wr_ok   = wr_req && ((state == S_RUN) || (state == S_FLUSH));
    assign busy    = (state == S_LOAD) || (state == S_RUN) || (state == S_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            fin_seen       <= '0;
            last_w         <= LW'(NREQ - 1);
            tag            <= '0;
            gnt            <= '0;
            rdata          <= '0;
            rvalid         <= '0;
            mem_rst        <= 1'b0;
            mem_read       <= 1'b0;
            mem_addr       <= '0;
            mem_we         <= 1'b0;
            mem_write_addr <= '0;
            mem_datai      <= '0;
            mem_done       <= 1'b0;
        end else begin
            gnt            <= '0;
            mem_rst        <= 1'b0;
            mem_read       <= 1'b0;
            mem_addr       <= '0;
            mem_done       <= 1'b0;
            mem_we         <= wr_ok;
            mem_write_addr <= wr_ok ? wr_addr : 8'd0;
            mem_datai      <= wr_ok ? wr_data : 32'd0;
            rvalid         <= mem_read ? tag_oh : '0;
            rdata          <= mem_read ? mem_rdata : 8'd0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        mem_rst  <= 1'b1;
                        fin_seen <= '0;
                    end
                end
                S_LOAD: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    fin_seen <= fin_seen | fin;
                    if (fin_all) begin
                        state <= S_FLUSH;
                    end else if (grant) begin
                        gnt      <= win_oh;
                        mem_read <= 1'b1;
                        mem_addr <= win_addr;
                        tag      <= win;
                        last_w   <= win;
                    end
                end
                S_FLUSH: begin
                    // Dump only once the last read return and any write have landed.
                    if (!mem_read && !mem_we && !wr_req) begin
                        mem_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_port_arbiter.sv
// Scoreboard bench for ofm_port_arbiter with a behavioural memory model.
// Expected grants/returns are queued by the stimulus and popped by a monitor.
module tb_ofm_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;

    typedef struct packed {
        logic [1:0] pe;
        logic [9:0] addr;
    } gexp_t;

    typedef struct packed {
        logic [1:0] pe;
        logic [7:0] data;
    } rexp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ-1:0]   fin = '0;
    logic              wr_req = 1'b0;
    logic [7:0]        wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        rdata;
    logic [NREQ-1:0]   rvalid;
    logic              busy;
    logic              mem_rst;
    logic              mem_read;
    logic [AW-1:0]     mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_write_addr;
    logic [31:0]       mem_datai;
    logic              mem_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    gexp_t gq[$];
    rexp_t rq[$];

    ofm_port_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .req(req),
        .req_addr(req_addr),
        .fin(fin),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .gnt(gnt),
        .rdata(rdata),
        .rvalid(rvalid),
        .busy(busy),
        .mem_rst(mem_rst),
        .mem_read(mem_read),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_we(mem_we),
        .mem_write_addr(mem_write_addr),
        .mem_datai(mem_datai),
        .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    logic [31:0] rd_word;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (mem_we) mem[mem_write_addr] <= mem_datai;
    end

    assign rd_word   = mem[mem_addr[9:2]];
    assign mem_rdata = rd_word[8*mem_addr[1:0] +: 8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [9:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic exp_rd(input logic [1:0] pe, input logic [9:0] a, input logic [7:0] d);
        gq.push_back('{pe: pe, addr: a});
        rq.push_back('{pe: pe, data: d});
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 0);
        chk({nm, "_rvalid"}, 32'(rvalid), 0);
        chk({nm, "_rdata"}, 32'(rdata), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_mem_rst"}, 32'(mem_rst), 0);
        chk({nm, "_mem_read"}, 32'(mem_read), 0);
        chk({nm, "_mem_addr"}, 32'(mem_addr), 0);
        chk({nm, "_mem_we"}, 32'(mem_we), 0);
        chk({nm, "_mem_wa"}, 32'(mem_write_addr), 0);
        chk({nm, "_mem_datai"}, mem_datai, 0);
        chk({nm, "_mem_done"}, 32'(mem_done), 0);
    endtask

    initial begin : monitor
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (mem_done) done_cnt++;
            if (gnt != '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 0);
                end else begin
                    g = gq.pop_front();
                    chk("gnt", 32'(gnt), 32'(4'b0001 << g.pe));
                    chk("gnt_mem_read", 32'(mem_read), 1);
                    chk("gnt_mem_addr", 32'(mem_addr), 32'(g.addr));
                end
            end
            if (rvalid != '0) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", 32'(rvalid), 0);
                end else begin
                    r = rq.pop_front();
                    chk("rvalid", 32'(rvalid), 32'(4'b0001 << r.pe));
                    chk("rdata", 32'(rdata), 32'(r.data));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bd_we = 1'b1;
        bd_addr = 8'd0; bd_data = 32'h1234_56DD; tick();
        bd_addr = 8'd3; bd_data = 32'h5566_7788; tick();
        bd_addr = 8'd5; bd_data = 32'hAABB_CCDD; tick();
        bd_we = 1'b0;
        rst = 1'b0;
        chk_idle("reset");

        // start -> LOAD (mem_rst) -> RUN
        start = 1'b1; tick(); start = 1'b0;
        chk("load_mem_rst", 32'(mem_rst), 1);
        chk("load_busy", 32'(busy), 1);
        chk("load_gnt", 32'(gnt), 0);
        chk("load_mem_read", 32'(mem_read), 0);
        tick();
        chk("run_mem_rst", 32'(mem_rst), 0);
        chk("run_busy", 32'(busy), 1);

        // All four held: PE0,1,2,3,0; start inside RUN is ignored.
        set_addr(0, 10'd22); set_addr(1, 10'd1);
        set_addr(2, 10'd23); set_addr(3, 10'd20);
        exp_rd(0, 10'd22, 8'hBB);
        exp_rd(1, 10'd1,  8'h56);
        exp_rd(2, 10'd23, 8'hAA);
        exp_rd(3, 10'd20, 8'hDD);
        exp_rd(0, 10'd22, 8'hBB);
        req = 4'b1111; start = 1'b1;
        tick(); start = 1'b0;
        chk("start_in_run_ignored", 32'(mem_rst), 0);
        repeat (4) tick();
        req = 4'b0000;
        repeat (3) tick();

        // PE2 alone, then round-robin continues from last_w=2.
        set_addr(2, 10'd0);
        exp_rd(2, 10'd0, 8'hDD);
        req = 4'b0100; tick(); req = 4'b0000;
        repeat (2) tick();
        exp_rd(3, 10'd20, 8'hDD);
        exp_rd(0, 10'd22, 8'hBB);
        req = 4'b1101; repeat (2) tick(); req = 4'b0000;
        repeat (2) tick();

        // Same-cycle write and read of word 3 returns old data.
        set_addr(1, 10'd12);
        wr_req = 1'b1; wr_addr = 8'd3; wr_data = 32'h1122_3344;
        exp_rd(1, 10'd12, 8'h88);
        req = 4'b0010; tick();
        wr_req = 1'b0;
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_wa", 32'(mem_write_addr), 3);
        chk("wr_mem_datai", mem_datai, 32'h1122_3344);
        set_addr(1, 10'd15);
        exp_rd(1, 10'd15, 8'h11);
        tick();
        set_addr(1, 10'd12);
        exp_rd(1, 10'd12, 8'h44);
        tick();
        req = 4'b0000;
        repeat (2) tick();

        // Finish: partial fin with a grant, then the rest with req pending.
        set_addr(0, 10'd22);
        exp_rd(0, 10'd22, 8'hBB);
        req = 4'b0001; fin = 4'b0101; tick();
        set_addr(1, 10'd1);
        req = 4'b0011; fin = 4'b1010; tick();
        fin = 4'b0000;
        chk("flush_gnt", 32'(gnt), 0);
        chk("flush_busy", 32'(busy), 1);
        chk("flush_no_done_yet", 32'(mem_done), 0);
        tick();
        chk("done_pulse", 32'(mem_done), 1);
        chk("done_busy", 32'(busy), 0);
        tick();
        chk("done_pulse_end", 32'(mem_done), 0);
        wr_req = 1'b1; wr_addr = 8'd7; wr_data = 32'hDEAD_BEEF; start = 1'b1;
        tick();
        wr_req = 1'b0; start = 1'b0;
        chk("done_wr_dropped", 32'(mem_we), 0);
        chk("done_start_ignored", 32'(mem_rst), 0);
        repeat (4) tick();
        chk("done_still_idle", 32'(busy), 0);
        req = 4'b0000;

        // Reset in RUN with a grant in flight.
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        set_addr(2, 10'd0);
        gq.push_back('{pe: 2'd2, addr: 10'd0});
        req = 4'b0100; tick();
        req = 4'b0000; rst = 1'b1; tick();
        rst = 1'b0;
        chk_idle("midrst");
        tick();
        chk("midrst_no_rvalid", 32'(rvalid), 0);
        chk("midrst_idle", 32'(busy), 0);

        for (int i = 0; i < 20 && (gq.size() != 0 || rq.size() != 0); i++) tick();
        chk("gnt_queue_drained", 32'(gq.size()), 0);
        chk("rd_queue_drained", 32'(rq.size()), 0);
        chk("done_count", 32'(done_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
